// File: rtl/fetch_stall_responder_if.sv
// Bus between the fetch stage and its environment: the stall control inputs, the
// program-memory port, and the IF/ID decode register outputs.
interface fetch_stall_responder_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  // Flow control has no valid/ready pair. stall or stall_pm high at a clock edge means
  // fetch must not advance that edge. ins_pm is sampled at that edge and is taken to be
  // mem[pm_addr] as it stood one edge earlier. valid_dec marks ins_dec as a real
  // instruction; a bubble leaves valid_dec low.
  logic             stall;
  logic             stall_pm;
  logic [31:0]      ins_pm;
  logic             branch_en;
  logic [PC_W-1:0]  branch_addr;
  logic [PC_W-1:0]  pm_addr;
  logic [31:0]      ins_dec;
  logic             valid_dec;
  logic [5:0]       op_dec;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       dbg_state;

  modport master (
    input  stall, stall_pm, ins_pm, branch_en, branch_addr,
    output pm_addr, ins_dec, valid_dec, op_dec, stall_cnt, dbg_state
  );

  modport slave (
    output stall, stall_pm, ins_pm, branch_en, branch_addr,
    input  pm_addr, ins_dec, valid_dec, op_dec, stall_cnt, dbg_state
  );
endinterface

// File: rtl/fetch_stall_responder.sv
// Instruction-fetch stage. It owns the PC, the IF/ID register and a one-entry hold slot,
// so that a stall neither loses nor repeats the instruction already in flight from memory.
module fetch_stall_responder #(
  parameter int              PC_W     = 32,
  parameter int              PC_STEP  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'h0,
  parameter int              CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  fetch_stall_responder_if.master bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ins_q, ins_d;
  logic             valid_q, valid_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            stall_any;
  logic [PC_W-1:0] pc_next;

  assign stall_any = bus.stall | bus.stall_pm;
  assign pc_next   = pc_q + PC_W'(PC_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      pc_q    <= RESET_PC;
      ins_q   <= NOP;
      valid_q <= 1'b0;
      hold_q  <= NOP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;

    // The counter only tracks stall activity, so a branch leaves it alone.
    if (stall_any && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.branch_en) begin
      pc_d    = bus.branch_addr;
      ins_d   = NOP;
      valid_d = 1'b0;
      hold_d  = NOP;
      state_d = S_EMPTY;
    end else if (stall_any) begin
      // stall bubbles decode; stall_pm alone freezes it through the defaults.
      if (bus.stall) begin
        ins_d   = NOP;
        valid_d = 1'b0;
      end
      if (state_q == S_RUN) begin
        hold_d  = bus.ins_pm;
        state_d = S_HOLD;
      end
    end else begin
      pc_d = pc_next;
      unique case (state_q)
        S_EMPTY: begin
          ins_d   = NOP;
          valid_d = 1'b0;
          state_d = S_RUN;
        end
        S_RUN: begin
          ins_d   = bus.ins_pm;
          valid_d = 1'b1;
        end
        S_HOLD: begin
          // ins_pm now reads mem[pc], which is exactly the word that follows hold.
          ins_d   = hold_q;
          valid_d = 1'b1;
          state_d = S_RUN;
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  assign bus.pm_addr   = pc_q;
  assign bus.ins_dec   = ins_q;
  assign bus.valid_dec = valid_q;
  assign bus.op_dec    = ins_q[31:26];
  assign bus.stall_cnt = cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stall_responder.sv
// Directed bench for fetch_stall_responder: a per-edge vector table plus hand-written
// sequences for asynchronous reset in HOLD, restart and counter saturation.
module tb_fetch_stall_responder;

  localparam int CNT_W = 4;
  localparam int N_VEC = 43;

  typedef struct {
    logic        stall;
    logic        stall_pm;
    logic        br_en;
    logic [31:0] br_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
    logic        exp_v;
    logic [3:0]  exp_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[N_VEC];
  logic [31:0] exp_q[$];

  fetch_stall_responder_if #(.PC_W(32), .CNT_W(CNT_W)) bus ();

  fetch_stall_responder #(
    .PC_W(32), .PC_STEP(1), .RESET_PC(32'h0), .NOP(32'h0), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program memory: synchronous read, mem[a] = 0x100 + a (mod 2^32)
  always @(posedge clk) bus.ins_pm <= 32'h100 + bus.pm_addr;

  function automatic vec_t mk(logic s, logic spm, logic br, logic [31:0] ba,
                              logic [31:0] pc, logic [31:0] ins, logic v, logic [3:0] cnt);
    vec_t r;
    r.stall = s; r.stall_pm = spm; r.br_en = br; r.br_addr = ba;
    r.exp_pc = pc; r.exp_ins = ins; r.exp_v = v; r.exp_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic spm, input logic br, input logic [31:0] ba);
    bus.stall       = s;
    bus.stall_pm    = spm;
    bus.branch_en   = br;
    bus.branch_addr = ba;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                               input logic v, input logic [3:0] cnt);
    logic [31:0] ins_v;
    ins_v = ins;
    chk({tag, " pm_addr"},   bus.pm_addr, pc);
    chk({tag, " ins_dec"},   bus.ins_dec, ins);
    chk({tag, " valid_dec"}, 32'(bus.valid_dec), 32'(v));
    chk({tag, " op_dec"},    32'(bus.op_dec), 32'(ins_v[31:26]));
    chk({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(cnt));
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 ns after the rising edge
  task automatic run_row(input int i);
    @(negedge clk);
    drive(tbl[i].stall, tbl[i].stall_pm, tbl[i].br_en, tbl[i].br_addr);
    @(posedge clk);
    #1;
    check_outputs($sformatf("row%0d", i), tbl[i].exp_pc, tbl[i].exp_ins,
                  tbl[i].exp_v, tbl[i].exp_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //           stall spm br  br_addr       pc            ins_dec       v  cnt
    tbl[0]  = mk(0, 0, 0, 32'h0,        32'h1,        32'h0,        0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        32'h2,        32'h100,      1, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,        32'h3,        32'h101,      1, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        32'h4,        32'h102,      1, 0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        32'h5,        32'h103,      1, 0);
    tbl[5]  = mk(0, 0, 0, 32'h0,        32'h6,        32'h104,      1, 0);
    // stall two edges with 0x105 in flight: two bubbles, then 0x105, 0x106
    tbl[6]  = mk(1, 0, 0, 32'h0,        32'h6,        32'h0,        0, 1);
    tbl[7]  = mk(1, 0, 0, 32'h0,        32'h6,        32'h0,        0, 2);
    tbl[8]  = mk(0, 0, 0, 32'h0,        32'h7,        32'h105,      1, 2);
    tbl[9]  = mk(0, 0, 0, 32'h0,        32'h8,        32'h106,      1, 2);
    // stall_pm three edges: decode frozen on 0x106
    tbl[10] = mk(0, 1, 0, 32'h0,        32'h8,        32'h106,      1, 3);
    tbl[11] = mk(0, 1, 0, 32'h0,        32'h8,        32'h106,      1, 4);
    tbl[12] = mk(0, 1, 0, 32'h0,        32'h8,        32'h106,      1, 5);
    tbl[13] = mk(0, 0, 0, 32'h0,        32'h9,        32'h107,      1, 5);
    tbl[14] = mk(0, 0, 0, 32'h0,        32'hA,        32'h108,      1, 5);
    // both stalls: bubble wins over freeze
    tbl[15] = mk(1, 1, 0, 32'h0,        32'hA,        32'h0,        0, 6);
    tbl[16] = mk(0, 0, 0, 32'h0,        32'hB,        32'h109,      1, 6);
    // branch while in HOLD with stall still high
    tbl[17] = mk(1, 0, 0, 32'h0,        32'hB,        32'h0,        0, 7);
    tbl[18] = mk(1, 0, 1, 32'h40,       32'h40,       32'h0,        0, 8);
    tbl[19] = mk(1, 0, 0, 32'h0,        32'h40,       32'h0,        0, 9);
    tbl[20] = mk(0, 0, 0, 32'h0,        32'h41,       32'h0,        0, 9);
    tbl[21] = mk(0, 0, 0, 32'h0,        32'h42,       32'h140,      1, 9);
    tbl[22] = mk(0, 0, 0, 32'h0,        32'h43,       32'h141,      1, 9);
    // branch near the top of the address space, stall_pm in EMPTY, PC wrap
    tbl[23] = mk(0, 0, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h0,        0, 9);
    tbl[24] = mk(0, 1, 0, 32'h0,        32'hFFFFFFFE, 32'h0,        0, 10);
    tbl[25] = mk(0, 0, 0, 32'h0,        32'hFFFFFFFF, 32'h0,        0, 10);
    tbl[26] = mk(0, 0, 0, 32'h0,        32'h0,        32'hFE,       1, 10);
    tbl[27] = mk(0, 0, 0, 32'h0,        32'h1,        32'hFF,       1, 10);
    tbl[28] = mk(0, 0, 0, 32'h0,        32'h2,        32'h100,      1, 10);
    // non-zero opcode field
    tbl[29] = mk(0, 0, 1, 32'hFBFFFFFF, 32'hFBFFFFFF, 32'h0,        0, 10);
    tbl[30] = mk(0, 0, 0, 32'h0,        32'hFC000000, 32'h0,        0, 10);
    tbl[31] = mk(0, 0, 0, 32'h0,        32'hFC000001, 32'hFC0000FF, 1, 10);
    tbl[32] = mk(0, 0, 0, 32'h0,        32'hFC000002, 32'hFC000100, 1, 10);
    // long stall: counter saturates at 15 and survives a branch
    tbl[33] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 11);
    tbl[34] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 12);
    tbl[35] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 13);
    tbl[36] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 14);
    tbl[37] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 15);
    tbl[38] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 15);
    tbl[39] = mk(1, 0, 0, 32'h0,        32'hFC000002, 32'h0,        0, 15);
    tbl[40] = mk(0, 1, 0, 32'h0,        32'hFC000002, 32'h0,        0, 15);
    tbl[41] = mk(1, 0, 1, 32'h10,       32'h10,       32'h0,        0, 15);
    tbl[42] = mk(0, 0, 0, 32'h0,        32'h11,       32'h0,        0, 15);

    // reset values
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 32'h0, 32'h0, 1'b0, 4'd0);
    reset = 1'b0;

    for (int i = 0; i < N_VEC; i++) run_row(i);

    // enter HOLD, then assert reset between edges
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk("hold state", 32'(bus.dbg_state), 32'd2);
    chk("hold pm_addr", bus.pm_addr, 32'h11);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async reset", 32'h0, 32'h0, 1'b0, 4'd0);
    chk("async reset state", 32'(bus.dbg_state), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    // restart must replay the opening sequence exactly
    for (int k = 0; k < 5; k++) exp_q.push_back(32'h100 + 32'(k));
    for (int i = 0; i < 6; i++) begin
      run_row(i);
      if (bus.valid_dec) begin
        if (exp_q.size() == 0) chk("restart extra ins", bus.ins_dec, 32'hDEAD_BEEF);
        else chk("restart stream", bus.ins_dec, exp_q.pop_front());
      end
    end
    chk("restart stream drained", 32'(exp_q.size()), 32'd0);

    // 20 stall edges from a cleared counter
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sat cnt %0d", i), 32'(bus.stall_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h80);
    @(posedge clk);
    #1;
    chk("sat after branch cnt", 32'(bus.stall_cnt), 32'd15);
    chk("sat after branch pm_addr", bus.pm_addr, 32'h80);
    chk("sat after branch valid", 32'(bus.valid_dec), 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
